// File: rtl/seq_muldiv.sv
// Iterative multiply/divide unit: unsigned/signed shift-add multiply and
// restoring divide on magnitudes, with sign fix-up in a final cycle.
module seq_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result_lo,
  output logic [WIDTH-1:0] result_hi,
  output logic             div_by_zero
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX, S_DONE} state_t;

  state_t           state_q;
  logic [CW-1:0]    cnt_q;
  logic             is_div_q;
  logic [WIDTH-1:0] mag_q;     // multiplicand or divisor magnitude
  logic [WIDTH-1:0] hi_q;      // upper accumulator / remainder
  logic [WIDTH-1:0] lo_q;      // multiplier-product low / quotient
  logic [WIDTH-1:0] a_raw_q;
  logic             neg_lo_q;
  logic             neg_hi_q;
  logic             dz_q;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] res_lo_q;
  logic [WIDTH-1:0] res_hi_q;
  logic             dz_out_q;

  logic             sign_a;
  logic             sign_b;
  logic [WIDTH-1:0] abs_a;
  logic [WIDTH-1:0] abs_b;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] mul_hi_d;
  logic [WIDTH-1:0] mul_lo_d;
  logic [WIDTH:0]   shl;
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] div_hi_d;
  logic [WIDTH-1:0] div_lo_d;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0] res_lo_d;
  logic [WIDTH-1:0] res_hi_d;

  always_comb begin
    sign_a = op[0] & a[WIDTH-1];
    sign_b = op[0] & b[WIDTH-1];
    abs_a  = sign_a ? (~a + 1'b1) : a;
    abs_b  = sign_b ? (~b + 1'b1) : b;

    // Multiply step: add then shift the {carry, hi, lo} chain right.
    sum      = {1'b0, hi_q} + {1'b0, {WIDTH{lo_q[0]}} & mag_q};
    mul_hi_d = sum[WIDTH:1];
    mul_lo_d = {sum[0], lo_q[WIDTH-1:1]};

    // Divide step: the shifted remainder needs WIDTH+1 bits before the trial.
    shl      = {hi_q, lo_q[WIDTH-1]};
    trial    = shl - {1'b0, mag_q};
    div_hi_d = trial[WIDTH] ? shl[WIDTH-1:0] : trial[WIDTH-1:0];
    div_lo_d = {lo_q[WIDTH-2:0], ~trial[WIDTH]};

    prod_fix = neg_lo_q ? (~{hi_q, lo_q} + 1'b1) : {hi_q, lo_q};
    if (is_div_q) begin
      if (dz_q) begin
        res_lo_d = '1;
        res_hi_d = a_raw_q;
      end else begin
        res_lo_d = neg_lo_q ? (~lo_q + 1'b1) : lo_q;
        res_hi_d = neg_hi_q ? (~hi_q + 1'b1) : hi_q;
      end
    end else begin
      res_lo_d = prod_fix[WIDTH-1:0];
      res_hi_d = prod_fix[2*WIDTH-1:WIDTH];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      is_div_q <= 1'b0;
      mag_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      a_raw_q  <= '0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
      dz_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      res_lo_q <= '0;
      res_hi_q <= '0;
      dz_out_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            is_div_q <= op[1];
            cnt_q    <= '0;
            hi_q     <= '0;
            a_raw_q  <= a;
            neg_lo_q <= sign_a ^ sign_b;
            neg_hi_q <= op[1] & sign_a;
            dz_q     <= op[1] & (b == '0);
            dz_out_q <= 1'b0;
            busy_q   <= 1'b1;
            if (op[1]) begin
              mag_q <= abs_b;
              lo_q  <= abs_a;
            end else begin
              mag_q <= abs_a;
              lo_q  <= abs_b;
            end
            state_q <= S_RUN;
          end
        end
        S_RUN: begin
          if (is_div_q) begin
            hi_q <= div_hi_d;
            lo_q <= div_lo_d;
          end else begin
            hi_q <= mul_hi_d;
            lo_q <= mul_lo_d;
          end
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CW'(WIDTH - 1)) state_q <= S_FIX;
        end
        S_FIX: begin
          res_lo_q <= res_lo_d;
          res_hi_q <= res_hi_d;
          dz_out_q <= dz_q;
          busy_q   <= 1'b0;
          done_q   <= 1'b1;
          state_q  <= S_DONE;
        end
        S_DONE: begin
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign result_lo   = res_lo_q;
  assign result_hi   = res_hi_q;
  assign div_by_zero = dz_out_q;

endmodule

// File: tb/tb_seq_muldiv.sv
// Randomized bench for seq_muldiv against an arithmetic reference model,
// plus directed corner cases, handshake timing, held start and mid-run reset.
module tb_seq_muldiv;
  localparam int W = 32;

  logic         clk;
  logic         reset;
  logic         start;
  logic [1:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] result_lo;
  logic [W-1:0] result_hi;
  logic         div_by_zero;

  int checks   = 0;
  int failures = 0;

  seq_muldiv #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .result_lo(result_lo), .result_hi(result_hi),
    .div_by_zero(div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference: plain integer arithmetic on sign-extended 64-bit values.
  task automatic model(input logic [1:0] m_op, input logic [W-1:0] m_a, input logic [W-1:0] m_b,
                       output logic [W-1:0] e_lo, output logic [W-1:0] e_hi, output logic e_dz);
    longint sa, sb, q, r;
    logic [63:0] p;
    sa = m_op[0] ? longint'($signed(m_a)) : longint'({32'b0, m_a});
    sb = m_op[0] ? longint'($signed(m_b)) : longint'({32'b0, m_b});
    e_dz = 1'b0;
    if (!m_op[1]) begin
      p = 64'(sa * sb);
      e_lo = p[31:0];
      e_hi = p[63:32];
    end else if (m_b == '0) begin
      e_lo = '1;
      e_hi = m_a;
      e_dz = 1'b1;
    end else begin
      q = sa / sb;
      r = sa % sb;
      e_lo = q[31:0];
      e_hi = r[31:0];
    end
  endtask

  // Runs one operation from an idle DUT; optionally pulses start mid-run.
  task automatic do_op(input logic [1:0] t_op, input logic [W-1:0] t_a, input logic [W-1:0] t_b,
                       input bit pulse_mid);
    logic [W-1:0] e_lo, e_hi;
    logic e_dz;
    int n, busy_cnt;
    model(t_op, t_a, t_b, e_lo, e_hi, e_dz);
    start = 1'b1; op = t_op; a = t_a; b = t_b;
    @(posedge clk); #1;
    check("busy_after_accept", busy, 1'b1);
    check("dz_clear_at_accept", div_by_zero, 1'b0);
    start = 1'b0; op = 2'($urandom); a = $urandom; b = $urandom;
    busy_cnt = busy ? 1 : 0;
    n = 0;
    while (!done && n < 100) begin
      @(posedge clk); #1;
      n++;
      if (busy) busy_cnt++;
      if (pulse_mid && n == 10) begin
        start = 1'b1; op = 2'($urandom); a = $urandom; b = $urandom;
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    // done rises on the edge WIDTH+1 after the accepting edge (WIDTH+2 edges counting it).
    check("latency", 64'(n), 64'(W + 1));
    check("busy_cycles", 64'(busy_cnt), 64'(W + 1));
    check("busy_in_done", busy, 1'b0);
    check("result_lo", result_lo, e_lo);
    check("result_hi", result_hi, e_hi);
    check("div_by_zero", div_by_zero, e_dz);
    $display("op=%0d a=%h b=%h -> hi=%h lo=%h dz=%0d", t_op, t_a, t_b, result_hi, result_lo, div_by_zero);
    @(posedge clk); #1;
    check("done_pulse", done, 1'b0);
    check("hold_lo", result_lo, e_lo);
    check("hold_hi", result_hi, e_hi);
  endtask

  initial begin
    logic [1:0]   r_op;
    logic [W-1:0] r_a, r_b;
    logic [W-1:0] e_lo, e_hi;
    logic         e_dz;
    int           done_t[$];
    int           cyc;

    reset = 1'b1; start = 1'b0; op = 2'b00; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_lo", result_lo, 32'h0);
    check("rst_hi", result_hi, 32'h0);
    check("rst_dz", div_by_zero, 1'b0);
    reset = 1'b0;

    // Directed corners
    do_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    do_op(2'b01, 32'hFFFF_FFFD, 32'd5, 1'b0);
    do_op(2'b01, 32'h8000_0000, 32'h8000_0000, 1'b0);
    do_op(2'b11, 32'hFFFF_FFF9, 32'd2, 1'b0);
    do_op(2'b10, 32'd100, 32'd7, 1'b0);
    do_op(2'b10, 32'd100, 32'd0, 1'b0);
    do_op(2'b00, 32'd12, 32'd13, 1'b0);
    do_op(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    do_op(2'b11, 32'hFFFF_FFF9, 32'd0, 1'b0);
    do_op(2'b10, 32'd5, 32'd9, 1'b1);
    do_op(2'b01, 32'h1234_5678, 32'h8765_4321, 1'b1);

    // Randomized operations with occasional zero/MIN/-1 operands
    for (int i = 0; i < 40; i++) begin
      r_op = 2'($urandom);
      r_a = $urandom;
      r_b = $urandom;
      if ($urandom_range(0, 7) == 0) r_b = '0;
      if ($urandom_range(0, 7) == 0) r_a = 32'h8000_0000;
      if ($urandom_range(0, 7) == 0) r_b = 32'hFFFF_FFFF;
      if ($urandom_range(0, 3) == 0) r_b = 32'($urandom_range(1, 20));
      do_op(r_op, r_a, r_b, (i % 3) == 0);
    end

    // start held high: one operation per WIDTH+3 cycles
    model(2'b00, 32'd1000, 32'd3000, e_lo, e_hi, e_dz);
    start = 1'b1; op = 2'b00; a = 32'd1000; b = 32'd3000;
    cyc = 0;
    while (done_t.size() < 3 && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
      if (done) begin
        done_t.push_back(cyc);
        check("held_lo", result_lo, e_lo);
        check("held_hi", result_hi, e_hi);
        $display("held start: done at cycle %0d lo=%h", cyc, result_lo);
      end
    end
    start = 1'b0;
    check("held_count", 64'(done_t.size()), 64'd3);
    if (done_t.size() == 3) begin
      check("held_period1", 64'(done_t[1] - done_t[0]), 64'(W + 3));
      check("held_period2", 64'(done_t[2] - done_t[1]), 64'(W + 3));
    end
    repeat (2) @(posedge clk);
    #1;

    // Reset mid-run, with div_by_zero previously set
    do_op(2'b10, 32'd77, 32'd0, 1'b0);
    start = 1'b1; op = 2'b00; a = 32'd9; b = 32'd9;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    check("midrst_busy", busy, 1'b0);
    check("midrst_done", done, 1'b0);
    check("midrst_lo", result_lo, 32'h0);
    check("midrst_hi", result_hi, 32'h0);
    check("midrst_dz", div_by_zero, 1'b0);
    $display("reset mid-run: busy=%0d done=%0d", busy, done);
    reset = 1'b0;
    do_op(2'b11, 32'hFFFF_FF00, 32'd7, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
